// File: rtl/spi_loader.sv
// Parses loader frames drained from the SPI slave receive FIFO into 32-bit bus writes
// (0xA5 frames) and start requests (0xC3 frames); aborts stalled frames after TIMEOUT idle cycles.
module spi_loader #(
    parameter int TIMEOUT = 65536
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [7:0]  fifo_rdata,
    input  logic        fifo_dr,
    output logic        fifo_rstrb,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    output logic        go,
    output logic [31:0] go_addr,
    output logic        busy,
    output logic [7:0]  err_count
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_LEN, S_DATA, S_WRITE, S_GO} state_t;

    state_t        state_q;
    logic          is_go_q;
    logic [1:0]    idx_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   go_addr_q;
    logic [8:0]    words_q;
    logic [TW-1:0] tmr_q;
    logic          mem_valid_q;
    logic          go_q;
    logic [7:0]    err_q;
    logic [7:0]    err_d;

    assign err_d = (err_q == 8'hFF) ? err_q : err_q + 8'd1;

    // Pops are gated only by state so a byte is consumed in the same cycle it is seen
    assign fifo_rstrb = fifo_dr & (state_q inside {S_IDLE, S_ADDR, S_LEN, S_DATA});
    assign mem_valid  = mem_valid_q;
    assign mem_addr   = {addr_q[31:2], 2'b00};
    assign mem_wdata  = wdata_q;
    assign mem_wstrb  = {4{mem_valid_q}};
    assign go         = go_q;
    assign go_addr    = go_addr_q;
    assign busy       = (state_q != S_IDLE);
    assign err_count  = err_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            is_go_q     <= 1'b0;
            idx_q       <= 2'd0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            go_addr_q   <= 32'd0;
            words_q     <= 9'd0;
            tmr_q       <= '0;
            mem_valid_q <= 1'b0;
            go_q        <= 1'b0;
            err_q       <= 8'd0;
        end else begin
            go_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (fifo_dr) begin
                        idx_q <= 2'd0;
                        tmr_q <= '0;
                        if (fifo_rdata == 8'hA5) begin
                            is_go_q <= 1'b0;
                            state_q <= S_ADDR;
                        end else if (fifo_rdata == 8'hC3) begin
                            is_go_q <= 1'b1;
                            state_q <= S_ADDR;
                        end else begin
                            err_q <= err_d;
                        end
                    end
                end
                S_ADDR, S_LEN, S_DATA: begin
                    if (fifo_dr) begin
                        tmr_q <= '0;
                        idx_q <= idx_q + 2'd1;
                        if (state_q == S_ADDR) begin
                            addr_q <= {addr_q[23:0], fifo_rdata};
                            if (idx_q == 2'd3)
                                state_q <= is_go_q ? S_GO : S_LEN;
                        end else if (state_q == S_LEN) begin
                            words_q <= (fifo_rdata == 8'd0) ? 9'd256 : {1'b0, fifo_rdata};
                            idx_q   <= 2'd0;
                            state_q <= S_DATA;
                        end else begin
                            // Little-endian word assembly: first byte lands in [7:0] after four shifts
                            wdata_q <= {fifo_rdata, wdata_q[31:8]};
                            if (idx_q == 2'd3) begin
                                mem_valid_q <= 1'b1;
                                state_q     <= S_WRITE;
                            end
                        end
                    end else if (tmr_q == TMR_LAST) begin
                        tmr_q   <= '0;
                        err_q   <= err_d;
                        state_q <= S_IDLE;
                    end else begin
                        tmr_q <= tmr_q + TW'(1);
                    end
                end
                S_WRITE: begin
                    if (mem_valid_q && mem_ready) begin
                        mem_valid_q <= 1'b0;
                        addr_q      <= addr_q + 32'd4;
                        words_q     <= words_q - 9'd1;
                        tmr_q       <= '0;
                        idx_q       <= 2'd0;
                        state_q     <= (words_q == 9'd1) ? S_IDLE : S_DATA;
                    end
                end
                S_GO: begin
                    go_q      <= 1'b1;
                    go_addr_q <= addr_q;
                    state_q   <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_loader.sv
// Bench for spi_loader: FIFO and bus models around the DUT, table vectors, directed
// corner sequences and randomized frames checked against a byte-stream frame parser.
module tb_spi_loader;
    localparam int TO = 32;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [7:0]  fifo_rdata = 8'h00;
    logic        fifo_dr = 1'b0;
    logic        fifo_rstrb;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        go;
    logic [31:0] go_addr;
    logic        busy;
    logic [7:0]  err_count;

    spi_loader #(.TIMEOUT(TO)) dut (
        .clk(clk), .resetn(resetn),
        .fifo_rdata(fifo_rdata), .fifo_dr(fifo_dr), .fifo_rstrb(fifo_rstrb),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .go(go), .go_addr(go_addr), .busy(busy), .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [127:0] bytes;
        int           n;
        int           nwr;
        logic [31:0]  a0, d0, a1, d1;
        int           ngo;
        logic [31:0]  ga;
        int           derr;
    } vec_t;

    logic [7:0]  q[$];
    logic [31:0] wr_a[$], wr_d[$], go_l[$];
    logic        pend_pop = 1'b0;
    bit          dr_rand = 1'b0;
    int          rdy_mode = 1;
    int          viol = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    int          exp_err = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, expv);
        end
    endtask

    // One clock of FIFO/bus modelling; inputs change at negedge, outputs sampled 1ns later
    task automatic tick();
        @(negedge clk);
        if (pend_pop && q.size() > 0) void'(q.pop_front());
        fifo_dr    = (q.size() > 0) && (!dr_rand || $urandom_range(3) != 0);
        fifo_rdata = (q.size() > 0) ? q[0] : 8'h00;
        mem_ready  = (rdy_mode == 0) ? 1'b0 : (rdy_mode == 1) ? 1'b1 : 1'($urandom_range(1));
        #1;
        pend_pop = fifo_rstrb;
        if (fifo_rstrb && !fifo_dr) viol++;
        if (fifo_rstrb && mem_valid) viol++;
        if (mem_valid && (mem_wstrb != 4'hF || mem_addr[1:0] != 2'b00)) viol++;
        if (resetn && mem_valid && mem_ready) begin
            wr_a.push_back(mem_addr);
            wr_d.push_back(mem_wdata);
        end
        if (go) go_l.push_back(go_addr);
    endtask

    task automatic wait_idle(input string nm, input int limit);
        int k = 0;
        while (!(q.size() == 0 && !pend_pop && !busy && !mem_valid) && k < limit) begin
            tick();
            k++;
        end
        check({nm, "_drained"}, 32'(k < limit), 32'd1);
        tick();
        tick();
    endtask

    task automatic wait_valid(input string nm, input int limit);
        int k = 0;
        while (!mem_valid && k < limit) begin
            tick();
            k++;
        end
        check({nm, "_valid"}, 32'(mem_valid), 32'd1);
    endtask

    task automatic push_bytes(input logic [127:0] b, input int n);
        for (int i = 0; i < n; i++) q.push_back(b[127 - 8*i -: 8]);
    endtask

    vec_t vecs[6];

    initial begin
        int wb, gb;
        logic [7:0]  stim[$];
        logic [31:0] ex_a[$], ex_d[$], ex_g[$];
        int          ex_err;

        vecs[0] = '{128'hA5000010_00011122_33440000_00000000, 10, 1,
                    32'h00001000, 32'h44332211, 0, 0, 0, 32'h0, 0};
        vecs[1] = '{128'hC3800000_00000000_00000000_00000000, 5, 0,
                    0, 0, 0, 0, 1, 32'h80000000, 0};
        vecs[2] = '{128'hA5FFFFFF_FC020102_03040506_07080000, 14, 2,
                    32'hFFFFFFFC, 32'h04030201, 32'h00000000, 32'h08070605, 0, 32'h0, 0};
        vecs[3] = '{128'hC3123456_7B000000_00000000_00000000, 5, 0,
                    0, 0, 0, 0, 1, 32'h1234567B, 0};
        vecs[4] = '{128'hA5000020_0301DEAD_BEEF0000_00000000, 10, 1,
                    32'h00002000, 32'hEFBEADDE, 0, 0, 0, 32'h0, 0};
        vecs[5] = '{128'h5AC30000_00100000_00000000_00000000, 6, 0,
                    0, 0, 0, 0, 1, 32'h00000010, 1};

        // Reset state
        repeat (3) tick();
        check("rst_busy", 32'(busy), 0);
        check("rst_mem_valid", 32'(mem_valid), 0);
        check("rst_go", 32'(go), 0);
        check("rst_go_addr", go_addr, 0);
        check("rst_err", 32'(err_count), 0);
        check("rst_wstrb", 32'(mem_wstrb), 0);
        check("rst_addr", mem_addr, 0);
        resetn = 1'b1;
        tick();

        // Table-driven frames
        for (int v = 0; v < 6; v++) begin
            wb = wr_a.size();
            gb = go_l.size();
            push_bytes(vecs[v].bytes, vecs[v].n);
            wait_idle($sformatf("v%0d", v), 200);
            exp_err += vecs[v].derr;
            check($sformatf("v%0d_nwr", v), 32'(wr_a.size() - wb), 32'(vecs[v].nwr));
            if (vecs[v].nwr >= 1 && wr_a.size() > wb) begin
                check($sformatf("v%0d_a0", v), wr_a[wb], vecs[v].a0);
                check($sformatf("v%0d_d0", v), wr_d[wb], vecs[v].d0);
            end
            if (vecs[v].nwr >= 2 && wr_a.size() > wb + 1) begin
                check($sformatf("v%0d_a1", v), wr_a[wb+1], vecs[v].a1);
                check($sformatf("v%0d_d1", v), wr_d[wb+1], vecs[v].d1);
            end
            check($sformatf("v%0d_ngo", v), 32'(go_l.size() - gb), 32'(vecs[v].ngo));
            if (vecs[v].ngo >= 1 && go_l.size() > gb)
                check($sformatf("v%0d_go_addr", v), go_l[gb], vecs[v].ga);
            check($sformatf("v%0d_err", v), 32'(err_count), 32'(exp_err));
        end

        // Slow bus: stall longer than TIMEOUT in WRITE
        rdy_mode = 0;
        wb = wr_a.size();
        push_bytes(128'hA5000000_06021122_33445566_77880000, 14);
        wait_valid("stall", 100);
        check("stall_addr0", mem_addr, 32'h00000004);
        check("stall_data0", mem_wdata, 32'h44332211);
        repeat (TO + 8) tick();
        check("stall_hold_valid", 32'(mem_valid), 1);
        check("stall_hold_addr", mem_addr, 32'h00000004);
        check("stall_no_timeout", 32'(err_count), 32'(exp_err));
        rdy_mode = 1;
        wait_idle("stall", 200);
        check("stall_nwr", 32'(wr_a.size() - wb), 2);
        if (wr_a.size() >= wb + 2) begin
            check("stall_a1", wr_a[wb+1], 32'h00000008);
            check("stall_d1", wr_d[wb+1], 32'h88776655);
        end
        check("stall_err", 32'(err_count), 32'(exp_err));

        // Bad opcodes then an abandoned frame
        push_bytes(128'h00FFA500_00000000_00000000_00000000, 3);
        for (int k = 0; k < 50 && (q.size() > 0 || pend_pop); k++) tick();
        tick();
        exp_err += 2;
        check("to_err_bad", 32'(err_count), 32'(exp_err));
        check("to_busy_pre", 32'(busy), 1);
        repeat (TO - 4) tick();
        check("to_busy_late", 32'(busy), 1);
        repeat (8) tick();
        exp_err += 1;
        check("to_busy_post", 32'(busy), 0);
        check("to_err_post", 32'(err_count), 32'(exp_err));

        // A gap shorter than TIMEOUT mid-frame must not abort
        wb = wr_a.size();
        push_bytes(128'hA5000030_00000000_00000000_00000000, 5);
        for (int k = 0; k < 50 && (q.size() > 0 || pend_pop); k++) tick();
        repeat (TO - 4) tick();
        check("gap_busy", 32'(busy), 1);
        push_bytes(128'h01AABBCC_DD000000_00000000_00000000, 5);
        wait_idle("gap", 200);
        check("gap_nwr", 32'(wr_a.size() - wb), 1);
        if (wr_a.size() > wb) begin
            check("gap_a0", wr_a[wb], 32'h00003000);
            check("gap_d0", wr_d[wb], 32'hDDCCBBAA);
        end
        check("gap_err", 32'(err_count), 32'(exp_err));

        // Randomized frames against a byte-stream parser
        for (int f = 0; f < 40; f++) begin
            int kind = $urandom_range(2);
            if (f == 5) kind = 0;
            if (kind == 0) begin
                int len = (f == 5) ? 0 : $urandom_range(1, 4);
                int nw = (len == 0) ? 256 : len;
                stim.push_back(8'hA5);
                for (int i = 0; i < 4; i++) stim.push_back(8'($urandom));
                stim.push_back(8'(len));
                for (int i = 0; i < 4 * nw; i++) stim.push_back(8'($urandom));
            end else if (kind == 1) begin
                stim.push_back(8'hC3);
                for (int i = 0; i < 4; i++) stim.push_back(8'($urandom));
            end else begin
                logic [7:0] b;
                b = 8'($urandom);
                while (b == 8'hA5 || b == 8'hC3) b = 8'($urandom);
                stim.push_back(b);
            end
        end
        ex_err = 0;
        begin
            int i = 0;
            while (i < stim.size()) begin
                logic [7:0] op;
                op = stim[i];
                i++;
                if (op == 8'hA5) begin
                    logic [31:0] a;
                    int nw;
                    a = {stim[i], stim[i+1], stim[i+2], stim[i+3]};
                    i += 4;
                    nw = (stim[i] == 8'd0) ? 256 : int'(stim[i]);
                    i++;
                    for (int w = 0; w < nw; w++) begin
                        ex_a.push_back(a & 32'hFFFF_FFFC);
                        ex_d.push_back({stim[i+3], stim[i+2], stim[i+1], stim[i]});
                        i += 4;
                        a = a + 32'd4;
                    end
                end else if (op == 8'hC3) begin
                    ex_g.push_back({stim[i], stim[i+1], stim[i+2], stim[i+3]});
                    i += 4;
                end else begin
                    ex_err++;
                end
            end
        end
        wb = wr_a.size();
        gb = go_l.size();
        dr_rand  = 1'b1;
        rdy_mode = 2;
        foreach (stim[i]) q.push_back(stim[i]);
        wait_idle("rnd", 40000);
        dr_rand  = 1'b0;
        rdy_mode = 1;
        exp_err += ex_err;
        check("rnd_nwr", 32'(wr_a.size() - wb), 32'(ex_a.size()));
        for (int k = 0; k < ex_a.size() && wb + k < wr_a.size(); k++) begin
            check($sformatf("rnd_a%0d", k), wr_a[wb+k], ex_a[k]);
            check($sformatf("rnd_d%0d", k), wr_d[wb+k], ex_d[k]);
        end
        check("rnd_ngo", 32'(go_l.size() - gb), 32'(ex_g.size()));
        for (int k = 0; k < ex_g.size() && gb + k < go_l.size(); k++)
            check($sformatf("rnd_go%0d", k), go_l[gb+k], ex_g[k]);
        check("rnd_err", 32'(err_count), 32'(exp_err));

        // err_count saturation
        for (int k = 0; k < 300; k++) q.push_back(8'h00);
        wait_idle("sat", 1000);
        check("sat_err", 32'(err_count), 255);

        // Reset during WRITE, then a fresh frame parses cleanly
        rdy_mode = 0;
        push_bytes(128'hA5000040_0001CAFE_BABE0000_00000000, 10);
        wait_valid("rstw", 100);
        resetn = 1'b0;
        tick();
        check("rstw_valid", 32'(mem_valid), 0);
        check("rstw_busy", 32'(busy), 0);
        check("rstw_err", 32'(err_count), 0);
        check("rstw_wstrb", 32'(mem_wstrb), 0);
        resetn   = 1'b1;
        rdy_mode = 1;
        wb = wr_a.size();
        push_bytes(vecs[0].bytes, vecs[0].n);
        wait_idle("rstw_after", 200);
        check("rstw_after_nwr", 32'(wr_a.size() - wb), 1);
        if (wr_a.size() > wb) begin
            check("rstw_after_a0", wr_a[wb], 32'h00001000);
            check("rstw_after_d0", wr_d[wb], 32'h44332211);
        end
        check("rstw_after_err", 32'(err_count), 0);

        check("protocol_viol", 32'(viol), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
